// File: rtl/adc_pkg.sv
// Shared constants and types for the ADC CIC decimation front end.
package adc_pkg;

    localparam int DIN_W    = 5;
    localparam int N_STAGES = 5;
    localparam int DEC_R    = 64;
    localparam int CNT_W    = $clog2(DEC_R);
    localparam int DOUT_W   = DIN_W + N_STAGES * CNT_W;

    typedef logic signed [DOUT_W-1:0] cic_word_t;

    function automatic cic_word_t sext(input logic signed [DIN_W-1:0] v);
        return cic_word_t'(v);
    endfunction

endpackage

// File: rtl/cic_integrator.sv
// One registered CIC integrator stage; wraps modulo 2^DOUT_W by design.
module cic_integrator
    import adc_pkg::*;
(
    input  logic      clk_i,
    input  logic      rst_ni,
    input  cic_word_t in_i,
    output cic_word_t acc_o
);

    cic_word_t acc_q;
    cic_word_t acc_d;

    assign acc_d = acc_q + in_i;
    assign acc_o = acc_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/adc_top.sv
// 5-stage CIC decimator (R=64, M=1): integrators at full rate, combs and
// output register updated once per 64 clocks with a one-cycle valid strobe.
module adc_top
    import adc_pkg::*;
(
    input  logic                     adc_clk,
    input  logic                     rstn,
    input  logic signed [DIN_W-1:0]  dat_in,
    output logic signed [DOUT_W-1:0] dat_out,
    output logic                     adc_clk_vld_out
);

    cic_word_t integ [N_STAGES];

    for (genvar k = 0; k < N_STAGES; k++) begin : g_integ
        cic_word_t stageIn;
        if (k == 0) begin : g_first
            assign stageIn = sext(dat_in);
        end else begin : g_rest
            assign stageIn = integ[k-1];
        end

        cic_integrator u_integ (
            .clk_i  (adc_clk),
            .rst_ni (rstn),
            .in_i   (stageIn),
            .acc_o  (integ[k])
        );
    end

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             strobe;

    cic_word_t comb_q [N_STAGES];
    cic_word_t comb_d [N_STAGES];
    cic_word_t dout_q;
    cic_word_t dout_d;
    logic      vld_q;
    logic      vld_d;

    assign cnt_d  = cnt_q + 1'b1;
    assign strobe = (cnt_q == CNT_W'(DEC_R - 1));

    // Comb chain is combinational within the strobe edge; delays only load then.
    always_comb begin
        cic_word_t x;
        x      = integ[N_STAGES-1];
        comb_d = comb_q;
        for (int k = 0; k < N_STAGES; k++) begin
            if (strobe) begin
                comb_d[k] = x;
            end
            x = x - comb_q[k];
        end
        dout_d = strobe ? x : dout_q;
        vld_d  = strobe;
    end

    always_ff @(posedge adc_clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            dout_q <= '0;
            vld_q  <= 1'b0;
            for (int k = 0; k < N_STAGES; k++) begin
                comb_q[k] <= '0;
            end
        end else begin
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            vld_q  <= vld_d;
            comb_q <= comb_d;
        end
    end

    assign dat_out         = dout_q;
    assign adc_clk_vld_out = vld_q;

endmodule

// File: tb/tb_adc_top.sv
// Self-checking bench for adc_top against an FIR-form CIC reference model.
module tb_adc_top;
    import adc_pkg::*;

    logic                     adc_clk = 1'b0;
    logic                     rstn    = 1'b0;
    logic signed [DIN_W-1:0]  dat_in  = 5'sd7;
    logic signed [DOUT_W-1:0] dat_out;
    logic                     adc_clk_vld_out;

    adc_top dut (
        .adc_clk         (adc_clk),
        .rstn            (rstn),
        .dat_in          (dat_in),
        .dat_out         (dat_out),
        .adc_clk_vld_out (adc_clk_vld_out)
    );

    always #5 adc_clk = ~adc_clk;

    localparam int TAPS = N_STAGES * (DEC_R - 1) + 1;

    int testCount = 0;
    int failCount = 0;
    int edgeCnt   = 0;
    int pulseIdx  = 0;
    int hist[$];
    longint h [TAPS];
    logic signed [DOUT_W-1:0] lastExp = '0;

    // Impulse response of the CIC is a 64-tap boxcar convolved with itself 5 times.
    function automatic void buildResponse();
        longint tmp [TAPS];
        foreach (h[i]) h[i] = (i < DEC_R) ? 64'sd1 : 64'sd0;
        for (int s = 1; s < N_STAGES; s++) begin
            foreach (tmp[i]) tmp[i] = 0;
            for (int i = 0; i < TAPS; i++) begin
                for (int j = 0; j < DEC_R; j++) begin
                    if (i + j < TAPS) tmp[i+j] += h[i];
                end
            end
            h = tmp;
        end
    endfunction

    // Sample taken at edge t reaches the comb input 5 edges later.
    function automatic longint refOut();
        longint acc = 0;
        int n = hist.size();
        for (int j = 0; j < TAPS; j++) begin
            int idx = n - N_STAGES - j;
            if (idx >= 1) acc += h[j] * longint'(hist[idx-1]);
        end
        return acc;
    endfunction

    task automatic checkOutput(input string tag, input logic expVld,
                               input logic signed [DOUT_W-1:0] expDat);
        testCount++;
        assert (adc_clk_vld_out === expVld) else begin
            failCount++;
            $error("[TB] FAIL %s_vld: observed %0b expected %0b", tag, adc_clk_vld_out, expVld);
        end
        testCount++;
        assert (dat_out === expDat) else begin
            failCount++;
            $error("[TB] FAIL %s_dat: observed %0d expected %0d", tag, dat_out, expDat);
        end
    endtask

    task automatic applyStimulus(input logic signed [DIN_W-1:0] v, input string tag);
        longint m;
        dat_in = v;
        @(posedge adc_clk);
        hist.push_back(int'(v));
        edgeCnt++;
        #1;
        if (edgeCnt % DEC_R == 0) begin
            m = refOut();
            lastExp = m[DOUT_W-1:0];
            pulseIdx++;
            checkOutput(tag, 1'b1, lastExp);
        end else begin
            checkOutput(tag, 1'b0, lastExp);
        end
    endtask

    // Asserts reset between clock edges and checks the clear is immediate.
    task automatic doReset(input string tag);
        #2;
        rstn = 1'b0;
        #1;
        checkOutput({tag, "_imm"}, 1'b0, '0);
        dat_in = 5'sd7;
        repeat (3) begin
            @(posedge adc_clk);
            #1;
            checkOutput({tag, "_hold"}, 1'b0, '0);
        end
        #2;
        rstn = 1'b1;
        hist.delete();
        edgeCnt  = 0;
        pulseIdx = 0;
        lastExp  = '0;
    endtask

    task automatic runDc(input logic signed [DIN_W-1:0] v, input int cycles,
                         input longint dcExp, input string tag);
        logic signed [DOUT_W-1:0] ex;
        ex = dcExp[DOUT_W-1:0];
        for (int c = 0; c < cycles; c++) begin
            applyStimulus(v, tag);
            if (edgeCnt % DEC_R == 0 && pulseIdx >= 7) begin
                testCount++;
                assert (dat_out === ex) else begin
                    failCount++;
                    $error("[TB] FAIL %s_gain: observed %0d expected %0d", tag, dat_out, ex);
                end
            end
        end
    endtask

    initial begin
        logic signed [DIN_W-1:0] r;
        buildResponse();

        doReset("reset");
        runDc(5'sd1, 8 * DEC_R, 64'sd1073741824, "dc_one");

        doReset("reset_neg");
        runDc(5'(-16), 160 * DEC_R, -64'sd17179869184, "dc_min");

        doReset("reset_pos");
        runDc(5'sd15, 160 * DEC_R, 64'sd16106127360, "dc_max");

        doReset("reset_pre_mid");
        runDc(5'sd1, 150, 64'sd1073741824, "pre_mid");
        doReset("reset_mid");
        runDc(5'sd1, 8 * DEC_R, 64'sd1073741824, "post_mid");

        doReset("reset_rand");
        for (int c = 0; c < 40 * DEC_R; c++) begin
            r = 5'($urandom_range(31));
            applyStimulus(r, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
